// File: rtl/serial_word_rx_if.sv
// Bus between the bit shifter side and the serial word receiver.
// The master drives the qualified serial bit stream; the slave returns decoded words.
interface serial_word_rx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             din;
  logic             en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             locked;
  logic             frame_done;

  modport master (
    output din,
    output en,
    input  dout,
    input  dout_valid,
    input  locked,
    input  frame_done
  );

  modport slave (
    input  din,
    input  en,
    output dout,
    output dout_valid,
    output locked,
    output frame_done
  );
endinterface

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: hunts for a WIDTH-bit sync word, then deserializes
// FRAME_WORDS words MSB first, each presented with a one-cycle valid pulse.
module serial_word_rx #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int unsigned      FRAME_WORDS = 4
) (
  input logic             clk,
  input logic             clr,
  serial_word_rx_if.slave bus
);

  localparam int unsigned FillW = $clog2(WIDTH + 1);
  localparam int unsigned BitW  = $clog2(WIDTH);
  localparam int unsigned WordW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [FillW-1:0] FillFull = FillW'(WIDTH);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FRAME_WORDS - 1);

  typedef enum logic {StHunt, StCollect} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_sreg;
  logic [FillW-1:0]   r_fill;
  logic [BitW-1:0]    r_bit;
  logic [WordW-1:0]   r_word;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_locked;
  logic               r_frame_done;

  state_e             w_state_nxt;
  logic [WIDTH-1:0]   w_sreg_nxt;
  logic [FillW-1:0]   w_fill_nxt;
  logic [BitW-1:0]    w_bit_nxt;
  logic [WordW-1:0]   w_word_nxt;
  logic [WIDTH-1:0]   w_dout_nxt;
  logic               w_dout_valid_nxt;
  logic               w_locked_nxt;
  logic               w_frame_done_nxt;

  logic [WIDTH-1:0]   w_shift;
  logic [FillW-1:0]   w_fill_inc;

  assign w_shift    = {r_sreg[WIDTH-2:0], bus.din};
  // Fill count including the current bit, saturating at WIDTH.
  assign w_fill_inc = (r_fill == FillFull) ? r_fill : r_fill + 1'b1;

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_fill_nxt       = r_fill;
    w_bit_nxt        = r_bit;
    w_word_nxt       = r_word;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_locked_nxt     = r_locked;
    w_frame_done_nxt = 1'b0;

    if (bus.en) begin
      unique case (r_state)
        StHunt: begin
          w_sreg_nxt = w_shift;
          w_fill_nxt = w_fill_inc;
          // Fill guard keeps reset zeros in sreg from completing a match.
          if ((w_fill_inc == FillFull) && (w_shift == SYNC)) begin
            w_state_nxt  = StCollect;
            w_bit_nxt    = '0;
            w_word_nxt   = '0;
            w_locked_nxt = 1'b1;
          end
        end
        StCollect: begin
          w_sreg_nxt = w_shift;
          if (r_bit == BitLast) begin
            w_dout_nxt       = w_shift;
            w_dout_valid_nxt = 1'b1;
            w_bit_nxt        = '0;
            w_word_nxt       = r_word + 1'b1;
            if (r_word == WordLast) begin
              // Last word: clearing sreg/fill stops its bits from forming a sync.
              w_frame_done_nxt = 1'b1;
              w_locked_nxt     = 1'b0;
              w_state_nxt      = StHunt;
              w_sreg_nxt       = '0;
              w_fill_nxt       = '0;
              w_word_nxt       = '0;
            end
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
        default: w_state_nxt = StHunt;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= StHunt;
      r_sreg       <= '0;
      r_fill       <= '0;
      r_bit        <= '0;
      r_word       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_fill       <= w_fill_nxt;
      r_bit        <= w_bit_nxt;
      r_word       <= w_word_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_locked     <= w_locked_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.locked     = r_locked;
  assign bus.frame_done = r_frame_done;

endmodule
